// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and packed-vector helper for the register file
package rf_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int REG_ZERO      = 0;
  localparam int PACK_MAX      = 1024;

  // Extract field idx of width w (w <= 64) from a packed port vector.
  function automatic logic [63:0] unpack_field(input logic [PACK_MAX-1:0] vec,
                                               input int idx, input int w);
    logic [PACK_MAX-1:0] sh;
    sh = vec >> (idx * w);
    return sh[63:0] & ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - read/write/reservation bus of the register file
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                rsv_ready;
  logic [AW:0]         busy_count;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, rsv_ready, busy_count
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, rsv_ready, busy_count
  );

endinterface

// File: rtl/rf_write_select.sv
// rtl/rf_write_select.sv - resolves which enabled write port targets one address
module rf_write_select
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int AW   = 5,
  parameter int NWR  = 2
) (
  input  logic [AW-1:0]       addr_i,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  output logic                hit_o,
  output logic [XLEN-1:0]     data_o
);

  // Later ports overwrite earlier ones, so the highest index wins; x0 never hits.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == addr_i) && (addr_i != AW'(REG_ZERO))) begin
        hit_o  = 1'b1;
        data_o = wr_data_i[j*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - multi-port register file with bypass and busy scoreboard
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);

  localparam int           AW   = $clog2(NREGS);
  localparam bit           BYP  = (BYPASS != 0);
  localparam logic [AW:0]  CNT1 = (AW+1)'(1);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];
  logic [XLEN-1:0]  wval  [NREGS];
  logic [NREGS-1:0] busy_q, busy_d, busy_eff, rel, set;
  logic [AW:0]      cnt_q, cnt_d;
  logic [NWR-1:0]   wr_en_g;
  logic             rsv_en_g, rsv_acc;

  // Writes and reservations are ignored while reset is held.
  assign wr_en_g  = reset ? '0 : bus.wr_en;
  assign rsv_en_g = bus.rsv_en & ~reset;

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    rf_write_select #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_wsel (
      .addr_i   (AW'(r)),
      .wr_en_i  (wr_en_g),
      .wr_addr_i(bus.wr_addr),
      .wr_data_i(bus.wr_data),
      .hit_o    (rel[r]),
      .data_o   (wval[r])
    );
  end

  logic [AW-1:0]   rd_a   [NRD];
  logic            rd_hit [NRD];
  logic [XLEN-1:0] rd_w   [NRD];

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign rd_a[i] = AW'(unpack_field(PACK_MAX'(bus.rd_addr), i, AW));

    rf_write_select #(.XLEN(XLEN), .AW(AW), .NWR(NWR)) u_byp (
      .addr_i   (rd_a[i]),
      .wr_en_i  (wr_en_g),
      .wr_addr_i(bus.wr_addr),
      .wr_data_i(bus.wr_data),
      .hit_o    (rd_hit[i]),
      .data_o   (rd_w[i])
    );

    assign bus.rd_data[i*XLEN +: XLEN] = (BYP && rd_hit[i]) ? rd_w[i] : mem_q[rd_a[i]];
    assign bus.rd_busy[i]              = busy_q[rd_a[i]] & ~(BYP && rd_hit[i]);
  end

  assign busy_eff      = BYP ? (busy_q & ~rel) : busy_q;
  assign bus.rsv_ready = ~busy_eff[bus.rsv_addr];
  assign rsv_acc       = rsv_en_g & bus.rsv_ready;

  // A reservation landing with a write keeps the bit set: the new producer is in flight.
  always_comb begin
    set = '0;
    if (rsv_acc && (bus.rsv_addr != AW'(REG_ZERO)))
      set[bus.rsv_addr] = 1'b1;
    busy_d = set | (busy_q & ~rel);
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int r = 0; r < NREGS; r++) begin
      if (busy_d[r] && !busy_q[r]) cnt_d = cnt_d + CNT1;
      if (busy_q[r] && !busy_d[r]) cnt_d = cnt_d - CNT1;
    end
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++)
      mem_d[r] = rel[r] ? wval[r] : mem_q[r];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= mem_d[r];
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.busy_count = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - bench for regfile_scoreboard, BYPASS=1 and BYPASS=0 builds
module tb_regfile_scoreboard;

  localparam int XLEN = 32, NREGS = 32, NRD = 2, NWR = 2, AW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0]   rd_addr_s;
  logic [NWR-1:0]      wr_en_s;
  logic [NWR*AW-1:0]   wr_addr_s;
  logic [NWR*XLEN-1:0] wr_data_s;
  logic                rsv_en_s;
  logic [AW-1:0]       rsv_addr_s;

  regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus0 ();
  regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus1 ();

  assign bus0.rd_addr = rd_addr_s;  assign bus1.rd_addr = rd_addr_s;
  assign bus0.wr_en   = wr_en_s;    assign bus1.wr_en   = wr_en_s;
  assign bus0.wr_addr = wr_addr_s;  assign bus1.wr_addr = wr_addr_s;
  assign bus0.wr_data = wr_data_s;  assign bus1.wr_data = wr_data_s;
  assign bus0.rsv_en  = rsv_en_s;   assign bus1.rsv_en  = rsv_en_s;
  assign bus0.rsv_addr = rsv_addr_s; assign bus1.rsv_addr = rsv_addr_s;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  logic [NRD*XLEN-1:0] o_data [2];
  logic [NRD-1:0]      o_busy [2];
  logic                o_rdy  [2];
  logic [AW:0]         o_cnt  [2];
  assign o_data[0] = bus0.rd_data;   assign o_data[1] = bus1.rd_data;
  assign o_busy[0] = bus0.rd_busy;   assign o_busy[1] = bus1.rd_busy;
  assign o_rdy[0]  = bus0.rsv_ready; assign o_rdy[1]  = bus1.rsv_ready;
  assign o_cnt[0]  = bus0.busy_count; assign o_cnt[1] = bus1.busy_count;

  int n_pass = 0, n_total = 0;
  bit running = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: architectural register contents and busy set, one per build.
  logic [XLEN-1:0] m_mem  [2][NREGS];
  logic            m_busy [2][NREGS];
  logic            w_hit  [NREGS];
  logic [XLEN-1:0] w_val  [NREGS];

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      w_hit[r] = 1'b0;
      w_val[r] = '0;
    end
    for (int j = 0; j < NWR; j++)
      if (!reset && wr_en_s[j] && wr_addr_s[j*AW +: AW] != 0) begin
        w_hit[wr_addr_s[j*AW +: AW]] = 1'b1;
        w_val[wr_addr_s[j*AW +: AW]] = wr_data_s[j*XLEN +: XLEN];
      end
  end

  function automatic logic exp_busy(input int b, input int a);
    return m_busy[b][a] && !(b == 1 && w_hit[a]);
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input int b, input int a);
    return (b == 1 && w_hit[a]) ? w_val[a] : m_mem[b][a];
  endfunction

  function automatic int popcount(input int b);
    int n = 0;
    for (int r = 0; r < NREGS; r++) if (m_busy[b][r]) n++;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int b = 0; b < 2; b++) begin
      if (reset) begin
        for (int r = 0; r < NREGS; r++) begin
          m_mem[b][r]  <= '0;
          m_busy[b][r] <= 1'b0;
        end
      end else begin
        for (int r = 0; r < NREGS; r++)
          if (w_hit[r]) begin
            m_mem[b][r]  <= w_val[r];
            m_busy[b][r] <= 1'b0;
          end
        if (rsv_en_s && !exp_busy(b, int'(rsv_addr_s)) && rsv_addr_s != 0)
          m_busy[b][rsv_addr_s] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (running) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NRD; i++) begin
          chk($sformatf("model b%0d rd_data%0d", b, i), 64'(o_data[b][i*XLEN +: XLEN]),
              64'(exp_data(b, int'(rd_addr_s[i*AW +: AW]))));
          chk($sformatf("model b%0d rd_busy%0d", b, i), 64'(o_busy[b][i]),
              64'(exp_busy(b, int'(rd_addr_s[i*AW +: AW]))));
        end
        chk($sformatf("model b%0d rsv_ready", b), 64'(o_rdy[b]), 64'(!exp_busy(b, int'(rsv_addr_s))));
        chk($sformatf("model b%0d busy_count", b), 64'(o_cnt[b]), 64'(popcount(b)));
      end
    end
  end

  task automatic idle();
    rd_addr_s = '0; wr_en_s = '0; wr_addr_s = '0; wr_data_s = '0;
    rsv_en_s = 1'b0; rsv_addr_s = '0;
  endtask
  task automatic wr(input int j, input int a, input logic [XLEN-1:0] d);
    wr_en_s[j] = 1'b1;
    wr_addr_s[j*AW +: AW] = AW'(a);
    wr_data_s[j*XLEN +: XLEN] = d;
  endtask
  task automatic rsv(input int a);
    rsv_en_s = 1'b1;
    rsv_addr_s = AW'(a);
  endtask
  task automatic rd(input int i, input int a);
    rd_addr_s[i*AW +: AW] = AW'(a);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] rdd(input int b, input int i);
    return 64'(o_data[b][i*XLEN +: XLEN]);
  endfunction

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_data0", rdd(1, 0), 0);
    chk("reset busy_count", 64'(o_cnt[1]), 0);
    chk("reset rsv_ready", 64'(o_rdy[1]), 1);
    reset = 1'b0;

    wr(0, 5, 32'hDEADBEEF); rsv(6); step();
    idle(); rd(0, 5); rd(1, 6); #1;
    chk("x5 written", rdd(1, 0), 64'hDEADBEEF);
    chk("x6 busy", 64'(o_busy[1][1]), 1);
    chk("count one", 64'(o_cnt[1]), 1);
    reset = 1'b1; wr(0, 5, 32'h1); rsv(6); #1;
    chk("async rst x5", rdd(1, 0), 0);
    chk("async rst x6 busy", 64'(o_busy[1][1]), 0);
    chk("async rst count", 64'(o_cnt[1]), 0);
    chk("async rst rsv_ready", 64'(o_rdy[1]), 1);
    step();
    chk("rst edge ignores write", rdd(1, 0), 0);
    chk("rst edge ignores rsv", 64'(o_cnt[1]), 0);
    reset = 1'b0; idle();

    rsv(7); step();
    idle(); rd(0, 7); #1;
    chk("x7 busy", 64'(o_busy[1][0]), 1);
    chk("x7 count", 64'(o_cnt[1]), 1);
    wr(1, 7, 32'h12345678); #1;
    chk("bypass data", rdd(1, 0), 64'h12345678);
    chk("bypass busy", 64'(o_busy[1][0]), 0);
    chk("nobypass data", rdd(0, 0), 0);
    chk("nobypass busy", 64'(o_busy[0][0]), 1);
    step(); idle(); #1;
    chk("x7 released count", 64'(o_cnt[1]), 0);

    wr(0, 3, 32'h11); wr(1, 3, 32'h22); step();
    idle(); wr(0, 0, 32'hFFFFFFFF); rd(0, 3); rd(1, 0); #1;
    chk("conflict x3", rdd(1, 0), 64'h22);
    chk("x0 no bypass", rdd(1, 1), 0);
    step(); idle(); rd(1, 0); #1;
    chk("x0 stays zero", rdd(1, 1), 0);
    chk("x0 stays zero b0", rdd(0, 1), 0);

    rsv(9); step(); #1;
    chk("waw stall", 64'(o_rdy[1]), 0);
    step();
    chk("stall count", 64'(o_cnt[1]), 1);
    wr(0, 9, 32'h99); #1;
    chk("release ready b1", 64'(o_rdy[1]), 1);
    chk("release ready b0", 64'(o_rdy[0]), 0);
    step(); idle(); rd(0, 9); #1;
    chk("x9 rebusy", 64'(o_busy[1][0]), 1);
    chk("x9 count", 64'(o_cnt[1]), 1);
    chk("x9 data", rdd(1, 0), 64'h99);
    chk("x9 b0 free", 64'(o_busy[0][0]), 0);
    chk("x9 b0 count", 64'(o_cnt[0]), 0);

    wr(0, 4, 32'hA5); rd(1, 4); #1;
    chk("b0 old value", rdd(0, 1), 0);
    chk("b1 bypass value", rdd(1, 1), 64'hA5);
    step(); idle(); rd(1, 4); #1;
    chk("b0 new value", rdd(0, 1), 64'hA5);

    wr(0, 9, 32'h0); step(); idle(); #1;
    chk("drain b1", 64'(o_cnt[1]), 0);
    for (int r = 1; r < NREGS; r++) begin
      rsv(r); step();
    end
    idle(); #1;
    chk("full count b1", 64'(o_cnt[1]), 31);
    chk("full count b0", 64'(o_cnt[0]), 31);
    for (int k = 0; k < 16; k++) begin
      idle();
      wr(0, 2*k + 1, XLEN'(k));
      if (2*k + 2 < NREGS) wr(1, 2*k + 2, XLEN'(k + 100));
      step();
      chk($sformatf("drain step %0d", k), 64'(o_cnt[1]),
          (2*k + 2 >= 31) ? 64'd0 : 64'(31 - (2*k + 2)));
    end
    idle(); step();
    running = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
